hwpe_stream_route_sequencer: RTL and testbench
==============================================

# hwpe_stream_route_sequencer

Packet-level routing controller placed directly upstream of the static HWPE-Stream demultiplexer. It accepts a route command carrying a destination index and a beat count, drives the demux select from a register that never changes while beats are in flight, and forwards exactly that many beats. Between packets it stalls the stream, so the downstream demux always sees a stable select.

## Interface
- NB_OUT_STREAMS, 2: number of demux outputs; sel width is SEL_W = $clog2(NB_OUT_STREAMS), minimum 1.
- LEN_WIDTH, 16: width of the beat-count field.
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- clear_i  in  1  synchronous soft clear; same effect as rst_i.
- route_valid_i  in  1  route command valid.
- route_ready_o  out  1  route command ready.
- route_dest_i  in  SEL_W  destination stream index.
- route_len_i  in  LEN_WIDTH  packet length in beats.
- push_i  hwpe_stream_intf_stream.sink  DATA_WIDTH  input stream (data, strb, valid, ready).
- pop_o  hwpe_stream_intf_stream.source  DATA_WIDTH  output stream feeding the demux.
- sel_o  out  SEL_W  registered select for the demux.
- busy_o  out  1  high in ROUTE.
- done_o  out  1  one-cycle pulse after the last beat, or after a zero-length command.
- remaining_o  out  LEN_WIDTH  beats still to forward.

## Operation
- FSM states are IDLE and ROUTE.
- IDLE:
  - route_ready_o=1, push_i.ready=0, pop_o.valid=0.
  - On route_valid_i & route_ready_o: sel_o<=route_dest_i and remaining<=route_len_i.
  - If route_len_i≠0, go to ROUTE. If route_len_i=0, stay in IDLE and pulse done_o next cycle.
- ROUTE:
  - route_ready_o=0.
  - pop_o.valid=push_i.valid; push_i.ready=pop_o.ready; data and strb pass through unchanged.
  - Each handshake (pop_o.valid & pop_o.ready) decrements remaining.
  - A handshake with remaining=1 moves the FSM to IDLE and pulses done_o.
- Data and strb are driven onto pop_o in all states. Only valid is gated.
- sel_o changes only on command acceptance in IDLE, never in ROUTE.
- route_dest_i ≥ NB_OUT_STREAMS is accepted as is; its handling is the downstream block's responsibility.
- done_o is registered: it is high for exactly one cycle, the cycle after the completing event.
- rst_i or clear_i, including mid-packet:
  - Next cycle: IDLE, remaining=0, sel_o=0, done_o=0.
  - The aborted packet produces no done_o.
  - Beats not yet forwarded stay in the upstream source.
- clear_i has priority over every other event in the same cycle.

## Timing
- Reset values: state=IDLE, sel_o=0, remaining_o=0, done_o=0, busy_o=0.
- Combinational values under reset: route_ready_o=1 (IDLE), pop_o.valid=0, push_i.ready=0.
- Command accepted at cycle t: ROUTE and the new sel_o are visible at t+1. The first beat can pass at t+1.
- Stream path: zero latency, combinational valid/ready/data. A beat is never duplicated or dropped.
- Last beat at cycle t: at t+1, done_o=1, state=IDLE, route_ready_o=1, so a new command can be accepted at t+1. The first beat of the next packet passes no earlier than t+2, giving one bubble per packet.
- Zero-length command at t: done_o=1 at t+1, and a new command can be accepted at t+1.
- remaining_o is registered and reflects handshakes up to the previous edge.
- A source asserting push_i.valid in IDLE must hold it and its data until ready, per the HWPE-Stream rules.

## Structure
- Shared package hwpe_stream_package holds:
  - the FSM enum route_seq_state_t {ROUTE_IDLE, ROUTE_ACTIVE};
  - no other new constants.
- No sub-module: one FSM, one LEN_WIDTH down-counter, one select register.
- Top-level integration instantiates this block followed by the static demux, with sel_o wired to the demux sel_i.

## Test plan
- Reset, then command dest=1 len=4 with push_i always valid and pop_o always ready:
  - exactly 4 beats pass, on cycles t+1..t+4;
  - sel_o=1 from t+1;
  - done_o high only at t+5;
  - remaining_o steps 4,3,2,1,0.
- len=3 with pop_o.ready toggling 1,0,1,0,1:
  - 3 beats pass in order, with data/strb unchanged;
  - push_i.ready mirrors pop_o.ready;
  - done_o fires one cycle after the 3rd handshake.
- Back-to-back commands (dest=0 len=2, then dest=1 len=1) with route_valid_i held:
  - the second command is accepted the cycle done_o is high;
  - sel_o switches 0→1 only then;
  - exactly one bubble cycle between packets.
- Zero-length command dest=1:
  - no beats pass, pop_o.valid stays 0;
  - done_o=1 the next cycle, sel_o=1.
- clear_i asserted after 2 of 5 beats:
  - next cycle IDLE, sel_o=0, remaining_o=0;
  - no done_o;
  - push_i.ready=0 until a new command is accepted.
- push_i.valid=1 in IDLE with no command for 10 cycles:
  - pop_o.valid=0 and push_i.ready=0 throughout;
  - no counter change.

Source files
------------

// File: rtl/hwpe_stream_package.sv
`default_nettype none
// ============================================================================
// Module      : hwpe_stream_package
// Description : Types shared by the HWPE-Stream routing blocks. It holds the
//               state encoding of the route sequencer FSM.
// Revision    : 1.0 - initial release
// ============================================================================
package hwpe_stream_package;

    // Route sequencer FSM: waiting for a command, or forwarding packet beats.
    typedef enum logic [0:0] {
        ROUTE_IDLE   = 1'b0,
        ROUTE_ACTIVE = 1'b1
    } route_seq_state_t;

endpackage
`default_nettype wire

// File: rtl/hwpe_stream_intf_stream.sv
`default_nettype none
// ============================================================================
// Module      : hwpe_stream_intf_stream
// Description : HWPE-Stream point-to-point interface with valid/ready
//               handshake, data and byte strobes.
//   source modport : drives valid, data, strb; receives ready
//   sink modport   : receives valid, data, strb; drives ready
// Revision    : 1.0 - initial release
// ============================================================================
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) ();

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport source (output valid, output data, output strb, input ready);
    modport sink   (input valid, input data, input strb, output ready);

endinterface
`default_nettype wire

// File: rtl/hwpe_stream_route_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : hwpe_stream_route_sequencer
// Description : Packet-level routing controller in front of a static
//               HWPE-Stream demux. A route command (destination, beat count)
//               loads a select register and a down-counter; exactly that many
//               beats are then forwarded. Between packets the stream is
//               stalled, so the demux select never moves under a live beat.
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   clear_i         synchronous soft clear (same effect as rst_i)
//   route_valid_i   route command valid
//   route_ready_o   route command ready (high in IDLE)
//   route_dest_i    destination stream index
//   route_len_i     packet length in beats (0 = empty packet)
//   push_i          incoming stream (sink)
//   pop_o           outgoing stream towards the demux (source)
//   sel_o           registered demux select
//   busy_o          packet in flight
//   done_o          one-cycle pulse after the last beat / empty command
//   remaining_o     beats still to forward
// Revision    : 1.0 - initial release
// ============================================================================
module hwpe_stream_route_sequencer
    import hwpe_stream_package::*;
#(
    parameter  int unsigned NB_OUT_STREAMS = 2,
    parameter  int unsigned LEN_WIDTH      = 16,
    localparam int unsigned SEL_W          = (NB_OUT_STREAMS > 1) ? $clog2(NB_OUT_STREAMS) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 route_valid_i,
    output logic                 route_ready_o,
    input  logic [SEL_W-1:0]     route_dest_i,
    input  logic [LEN_WIDTH-1:0] route_len_i,
    hwpe_stream_intf_stream.sink   push_i,
    hwpe_stream_intf_stream.source pop_o,
    output logic [SEL_W-1:0]     sel_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [LEN_WIDTH-1:0] remaining_o
);

    localparam logic [LEN_WIDTH-1:0] c_len_one = LEN_WIDTH'(1);

    route_seq_state_t      r_state;
    route_seq_state_t      w_state_next;
    logic [SEL_W-1:0]      r_sel;
    logic [LEN_WIDTH-1:0]  r_remaining;
    logic                  r_done;

    logic w_active;
    logic w_accept;
    logic w_handshake;
    logic w_last_beat;

    assign w_active    = (r_state == ROUTE_ACTIVE);
    assign w_accept    = !w_active && route_valid_i;
    assign w_handshake = w_active && push_i.valid && pop_o.ready;
    assign w_last_beat = w_handshake && (r_remaining == c_len_one);

    // Stream path: data/strb always pass, only the handshake is gated so
    // nothing moves while the select could be changing.
    assign pop_o.valid   = w_active && push_i.valid;
    assign pop_o.data    = push_i.data;
    assign pop_o.strb    = push_i.strb;
    assign push_i.ready  = w_active && pop_o.ready;

    assign route_ready_o = !w_active;
    assign busy_o        = w_active;
    assign sel_o         = r_sel;
    assign done_o        = r_done;
    assign remaining_o   = r_remaining;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ROUTE_IDLE: begin
                // An empty packet completes without ever entering ROUTE.
                if (w_accept && (route_len_i != '0)) begin
                    w_state_next = ROUTE_ACTIVE;
                end
            end
            ROUTE_ACTIVE: begin
                if (w_last_beat) begin
                    w_state_next = ROUTE_IDLE;
                end
            end
            default: w_state_next = ROUTE_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_state     <= ROUTE_IDLE;
            r_sel       <= '0;
            r_remaining <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= 1'b0;
            if (w_accept) begin
                r_sel       <= route_dest_i;
                r_remaining <= route_len_i;
                r_done      <= (route_len_i == '0);
            end else if (w_handshake) begin
                r_remaining <= r_remaining - c_len_one;
                r_done      <= w_last_beat;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hwpe_stream_route_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_hwpe_stream_route_sequencer
// Description : Self-checking bench for hwpe_stream_route_sequencer. A table
//               of route commands with downstream ready patterns is applied
//               in a loop; hand-written sequences cover back-to-back
//               commands, soft clear mid-packet and idle stalling. Expected
//               beats are queued when a command is issued and popped as the
//               DUT forwards them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hwpe_stream_route_sequencer;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned LEN_WIDTH  = 16;

    typedef struct {
        logic [0:0]  sel;
        logic [31:0] data;
        logic [3:0]  strb;
    } beat_t;

    typedef struct {
        logic [0:0]  dest;
        logic [15:0] len;
        logic [7:0]  rdy;     // pop ready per ROUTE cycle, bit 0 first
        int          cycles;  // ROUTE cycles until the last handshake
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst_i;
    logic                 clear_i;
    logic                 route_valid_i;
    logic                 route_ready_o;
    logic [0:0]           route_dest_i;
    logic [LEN_WIDTH-1:0] route_len_i;
    logic [0:0]           sel_o;
    logic                 busy_o;
    logic                 done_o;
    logic [LEN_WIDTH-1:0] remaining_o;

    hwpe_stream_intf_stream #(.DATA_WIDTH(DATA_WIDTH)) push ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(DATA_WIDTH)) pop ();

    hwpe_stream_route_sequencer #(
        .NB_OUT_STREAMS(2),
        .LEN_WIDTH     (LEN_WIDTH)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .clear_i      (clear_i),
        .route_valid_i(route_valid_i),
        .route_ready_o(route_ready_o),
        .route_dest_i (route_dest_i),
        .route_len_i  (route_len_i),
        .push_i       (push),
        .pop_o        (pop),
        .sel_o        (sel_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .remaining_o  (remaining_o)
    );

    always #5 clk = ~clk;

    int    n_vec   = 0;
    int    n_err   = 0;
    int    beat_id = 0;
    bit    mon_en  = 1'b0;
    bit    hs;
    beat_t exp_q[$];
    vec_t  vecs[5];

    function automatic logic [31:0] bdata(input int id);
        logic [7:0] b;
        b = id[7:0];
        return {8'hA5, b, ~b, 8'h3C};
    endfunction

    function automatic logic [3:0] bstrb(input int id);
        return id[3:0] ^ 4'h9;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at +4 after a rising edge; returns at +1 after the next edge with
    // the source advanced to its next beat if the current one was taken.
    task automatic adv();
        hs = push.valid && push.ready;
        @(posedge clk);
        #1;
        if (hs) beat_id++;
        push.data = bdata(beat_id);
        push.strb = bstrb(beat_id);
    endtask

    task automatic expect_beats(input logic [0:0] sel, input int n);
        for (int b = 0; b < n; b++) begin
            exp_q.push_back('{sel: sel, data: bdata(beat_id + b), strb: bstrb(beat_id + b)});
        end
    endtask

    // Scoreboard side: every forwarded beat must be the next expected one,
    // and the stream gating must follow the busy state.
    always @(negedge clk) begin
        if (mon_en) begin
            n_vec++;
            if (pop.valid !== (busy_o && push.valid) || push.ready !== (busy_o && pop.ready) ||
                pop.data !== push.data || pop.strb !== push.strb) begin
                n_err++;
                $display("FAIL stream_gate: pop.v=%b push.r=%b busy=%b push.v=%b pop.r=%b at %0t",
                         pop.valid, push.ready, busy_o, push.valid, pop.ready, $time);
            end
            if (pop.valid && pop.ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL extra_beat: data %h forwarded, none expected at %0t", pop.data, $time);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    if (pop.data !== e.data || pop.strb !== e.strb || sel_o !== e.sel) begin
                        n_err++;
                        $display("FAIL beat: got d=%h s=%h sel=%0d expected d=%h s=%h sel=%0d",
                                 pop.data, pop.strb, sel_o, e.data, e.strb, e.sel);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{dest: 1'b1, len: 16'd4, rdy: 8'hFF,        cycles: 4};
        vecs[1] = '{dest: 1'b0, len: 16'd3, rdy: 8'h15,        cycles: 5};
        vecs[2] = '{dest: 1'b1, len: 16'd0, rdy: 8'hFF,        cycles: 0};
        vecs[3] = '{dest: 1'b0, len: 16'd1, rdy: 8'hFE,        cycles: 2};
        vecs[4] = '{dest: 1'b1, len: 16'd6, rdy: 8'b1011_0111, cycles: 8};

        rst_i         = 1'b1;
        clear_i       = 1'b0;
        route_valid_i = 1'b0;
        route_dest_i  = '0;
        route_len_i   = '0;
        push.valid    = 1'b1;
        push.data     = bdata(0);
        push.strb     = bstrb(0);
        pop.ready     = 1'b1;

        // Reset state, with a source already offering data.
        @(posedge clk);
        #1;
        #3;
        chk("rst_sel", sel_o, 0);
        chk("rst_remaining", remaining_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_route_ready", route_ready_o, 1);
        chk("rst_pop_valid", pop.valid, 0);
        chk("rst_push_ready", push.ready, 0);
        adv();
        rst_i  = 1'b0;
        mon_en = 1'b1;

        // Table-driven packets.
        for (int i = 0; i < 5; i++) begin
            int unsigned rem;
            int          c;
            route_valid_i = 1'b1;
            route_dest_i  = vecs[i].dest;
            route_len_i   = vecs[i].len;
            pop.ready     = 1'b1;
            expect_beats(vecs[i].dest, int'(vecs[i].len));
            #3;
            chk("accept_ready", route_ready_o, 1);
            chk("accept_pop_valid", pop.valid, 0);
            adv();
            route_valid_i = 1'b0;
            rem = vecs[i].len;
            c   = 0;
            while (rem != 0 && c < 20) begin
                pop.ready = vecs[i].rdy[c % 8];
                #3;
                chk("route_busy", busy_o, 1);
                chk("route_sel", sel_o, vecs[i].dest);
                chk("route_remaining", remaining_o, rem);
                chk("route_done_low", done_o, 0);
                if (pop.ready) rem--;
                c++;
                adv();
            end
            #3;
            chk("route_cycles", c, vecs[i].cycles);
            chk("done_pulse", done_o, 1);
            chk("done_sel", sel_o, vecs[i].dest);
            chk("done_busy", busy_o, 0);
            chk("done_route_ready", route_ready_o, 1);
            chk("done_remaining", remaining_o, 0);
            adv();
            #3;
            chk("done_single", done_o, 0);
            adv();
        end

        // Back-to-back commands with route_valid held: second accepted on done.
        route_valid_i = 1'b1;
        route_dest_i  = 1'b0;
        route_len_i   = 16'd2;
        pop.ready     = 1'b1;
        expect_beats(1'b0, 2);
        #3;
        adv();
        route_dest_i = 1'b1;
        route_len_i  = 16'd1;
        #3;
        chk("b2b_busy_a", busy_o, 1);
        chk("b2b_sel_a", sel_o, 0);
        adv();
        #3;
        chk("b2b_rem_a", remaining_o, 1);
        adv();
        expect_beats(1'b1, 1);
        #3;
        chk("b2b_done_a", done_o, 1);
        chk("b2b_sel_hold", sel_o, 0);
        chk("b2b_ready", route_ready_o, 1);
        chk("b2b_bubble", pop.valid, 0);
        adv();
        route_valid_i = 1'b0;
        #3;
        chk("b2b_sel_b", sel_o, 1);
        chk("b2b_busy_b", busy_o, 1);
        chk("b2b_valid_b", pop.valid, 1);
        adv();
        #3;
        chk("b2b_done_b", done_o, 1);
        chk("b2b_idle", busy_o, 0);
        adv();

        // Soft clear after 2 of 5 beats.
        route_valid_i = 1'b1;
        route_dest_i  = 1'b1;
        route_len_i   = 16'd5;
        expect_beats(1'b1, 2);
        #3;
        adv();
        route_valid_i = 1'b0;
        #3;
        adv();
        #3;
        adv();
        clear_i   = 1'b1;
        pop.ready = 1'b0;
        #3;
        chk("clr_pre_rem", remaining_o, 3);
        adv();
        clear_i   = 1'b0;
        pop.ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #3;
            chk("clr_busy", busy_o, 0);
            chk("clr_sel", sel_o, 0);
            chk("clr_rem", remaining_o, 0);
            chk("clr_no_done", done_o, 0);
            chk("clr_push_ready", push.ready, 0);
            adv();
        end

        // Source valid in IDLE with no command: fully stalled.
        for (int k = 0; k < 10; k++) begin
            #3;
            chk("stall_pop_valid", pop.valid, 0);
            chk("stall_push_ready", push.ready, 0);
            chk("stall_rem", remaining_o, 0);
            adv();
        end

        #3;
        chk("queue_empty", exp_q.size(), 0);
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
